// File: rtl/switch_debouncer.sv
// switch_debouncer: conditions a raw, bouncy 1-bit input (switch or button).
// The input passes through a two-flop synchronizer. A four-state FSM then
// accepts a new level only after STABLE_CYCLES consecutive identical
// synchronized samples. The block produces a clean level y, one-cycle
// rise/fall strobes, and a toggle that flips on every accepted rise.
//
// Handshake: none. The input is level-sampled on every clock. All outputs
// are registered and valid every cycle.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  output logic       y,
  output logic       rise,
  output logic       fall,
  output logic       toggle,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } state_e;

  // Count value at which the next agreeing sample completes qualification.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             y_q;
  logic             rise_q;
  logic             fall_q;
  logic             toggle_q;

  // Two-flop synchronizer for the asynchronous input; the FSM sees only s2_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= a;
      s2_q <= s1_q;
    end
  end

  // Qualification FSM with registered level, strobes and toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      y_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      // Strobes last exactly one cycle unless a transition re-asserts them.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        ST_LOW: begin
          if (s2_q) begin
            state_q <= ST_CHK_HIGH;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_CHK_HIGH: begin
          if (!s2_q) begin
            // Excursion too short: discard it silently.
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= ST_HIGH;
            y_q      <= 1'b1;
            rise_q   <= 1'b1;
            toggle_q <= ~toggle_q;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s2_q) begin
            state_q <= ST_CHK_LOW;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_CHK_LOW: begin
          if (s2_q) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_LOW;
            y_q     <= 1'b0;
            fall_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign y         = y_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign toggle    = toggle_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer. A behavioural model predicts y, rise, fall
// and toggle from a window of the last N synchronized samples. Directed
// scenarios are followed by randomized bouncy stimulus.
module tb_switch_debouncer;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a   = 1'b0;
  logic       y, rise, fall, toggle;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  switch_debouncer #(.STABLE_CYCLES(N), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .y         (y),
    .rise      (rise),
    .fall      (fall),
    .toggle    (toggle),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A new level is accepted once the last N synchronized samples all
  // disagree with the current level. The synchronizer is a 2-deep delay.
  logic m_s1, m_s2, m_y, m_rise, m_fall, m_tog;
  logic hist_q[$];

  task automatic model_step(input logic in_a, input logic in_rst);
    bit all_opp;
    if (in_rst) begin
      m_s1 = 0; m_s2 = 0; m_y = 0; m_rise = 0; m_fall = 0; m_tog = 0;
      hist_q.delete();
    end else begin
      hist_q.push_back(m_s2);
      if (hist_q.size() > N) void'(hist_q.pop_front());
      m_s2 = m_s1;
      m_s1 = in_a;
      m_rise = 0;
      m_fall = 0;
      all_opp = (hist_q.size() == N);
      foreach (hist_q[i]) if (hist_q[i] == m_y) all_opp = 0;
      if (all_opp) begin
        m_y = ~m_y;
        if (m_y) begin
          m_rise = 1;
          m_tog  = ~m_tog;
        end else begin
          m_fall = 1;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  int rise_cnt = 0;
  int fall_cnt = 0;
  int rise_at  = 0;   // step index within last run() where rise was seen
  int fall_at  = 0;

  // One clock: drive inputs, advance model, sample DUT 1 time unit later.
  task automatic step(input logic v, input logic r);
    a   = v;
    rst = r;
    @(posedge clk);
    model_step(v, r);
    #1;
    check("y", y, m_y);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("toggle", toggle, m_tog);
    if (rise) rise_cnt++;
    if (fall) fall_cnt++;
  endtask

  task automatic run(input logic v, input int n);
    rise_at = 0;
    fall_at = 0;
    for (int i = 1; i <= n; i++) begin
      step(v, 1'b0);
      if (rise && rise_at == 0) rise_at = i;
      if (fall && fall_at == 0) fall_at = i;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0, f0, len;
    logic v;

    // Reset with a held high.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check("rst_state", dbg_state, 0);
    end
    run(1'b1, 10);
    check("rst_release_lat", rise_at, 6);
    check("rst_rise_cnt", rise_cnt, 1);
    run(1'b0, 10);

    // Clean rise and fall.
    r0 = rise_cnt; f0 = fall_cnt;
    run(1'b1, 8);
    check("clean_rise_lat", rise_at, 6);
    run(1'b0, 8);
    check("clean_fall_lat", fall_at, 6);
    check("clean_toggle", toggle, 0);
    check("clean_pulses", (rise_cnt - r0) + (fall_cnt - f0), 2);

    // Bounce rejection: 1x3, 0, 1x3, then low.
    r0 = rise_cnt; f0 = fall_cnt;
    run(1'b1, 3); run(1'b0, 1); run(1'b1, 3); run(1'b0, 10);
    check("bounce_y", y, 0);
    check("bounce_rise", rise_cnt - r0, 0);
    check("bounce_fall", fall_cnt - f0, 0);

    // Bounce then settle high.
    r0 = rise_cnt;
    run(1'b1, 1); run(1'b0, 1); run(1'b1, 1); run(1'b0, 1);
    run(1'b1, 10);
    check("settle_lat", rise_at, 6);
    check("settle_rise", rise_cnt - r0, 1);
    run(1'b0, 10);

    // Reset while counting in CHK_HIGH (cnt=2 at the reset edge).
    r0 = rise_cnt;
    run(1'b1, 4);
    step(1'b1, 1'b1);
    check("midq_state", dbg_state, 0);
    check("midq_y", y, 0);
    check("midq_rise", rise_cnt - r0, 0);
    run(1'b1, 10);
    check("midq_relat", rise_at, 6);
    run(1'b0, 10);

    // Toggle count over three press/release cycles from reset.
    step(1'b0, 1'b1);
    r0 = rise_cnt; f0 = fall_cnt;
    for (int k = 0; k < 3; k++) begin
      run(1'b1, 10);
      check("tog_seq", toggle, (k % 2 == 0) ? 1 : 0);
      run(1'b0, 10);
    end
    check("tog_rises", rise_cnt - r0, 3);
    check("tog_falls", fall_cnt - f0, 3);

    // Randomized bouncy input with occasional resets.
    for (int k = 0; k < 600; k++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) step(v, ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Synchronous debouncer and edge detector that conditions a raw, asynchronous 1-bit input, such as a slide switch or push button, before it drives a logic gate input. Its output `y` connects directly to the `a` input of the downstream `not_gate`, so the gate sees only clean, glitch-free transitions. The block also provides single-cycle rise and fall strobes and a toggle output for board-level demos.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical synchronized samples needed to accept a new level. Legal range is 2 .. 2^CNT_W-1.
- `CNT_W`, default 8: width of the stability counter.
- `clk`  input  1: single system clock; all logic is on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `a`  input  1: raw, asynchronous, bouncy input.
- `y`  output  1: debounced level; feeds `not_gate.a`.
- `rise`  output  1: one-cycle pulse when `y` goes 0->1.
- `fall`  output  1: one-cycle pulse when `y` goes 1->0.
- `toggle`  output  1: inverts on every `rise`.

## Operation
- **Synchronizer:** two flops, `a` -> `s1` -> `s2`. The FSM observes only `s2`.
- **FSM states:** LOW (y=0), CHK_HIGH (y=0), HIGH (y=1), CHK_LOW (y=1).
- **LOW:** if s2=1, go to CHK_HIGH and set cnt<=1. Otherwise stay, with cnt=0.
- **CHK_HIGH:**
  - s2=0: return to LOW, cnt<=0. This discards the glitch; no pulse.
  - s2=1 and cnt==STABLE_CYCLES-1: go to HIGH, y<=1, rise<=1, toggle<=~toggle, cnt<=0.
  - s2=1 otherwise: cnt<=cnt+1.
- **HIGH:** the mirror of LOW. If s2=0, go to CHK_LOW and set cnt<=1.
- **CHK_LOW:**
  - s2=1: return to HIGH, cnt<=0.
  - s2=0 and cnt==STABLE_CYCLES-1: go to LOW, y<=0, fall<=1, cnt<=0.
  - s2=0 otherwise: cnt<=cnt+1.
- **Outputs:** all registered. `rise` and `fall` default to 0 each cycle and are never both 1.
- **Counter width:** cnt never exceeds STABLE_CYCLES-1, so it never wraps.
- **Reset:** rst=1 at a clock edge forces s1, s2, cnt, y, rise, fall and toggle to 0 and the state to LOW. Reset has priority over all other conditions, including mid-count and during a rise/fall pulse. A pending pulse is dropped.
- **Input high during reset:** if `a` is held high through reset, the block re-qualifies it after release through the normal path. y rises at the earliest STABLE_CYCLES+2 edges after release.

## Timing
- **Reset values:** y=0, rise=0, fall=0, toggle=0, state LOW.
- **Rise latency:** if `a` settles high before edge E0 and stays high:
  - s1=1 after E0.
  - s2=1 after E1.
  - The FSM samples s2=1 at edges E2 .. E(STABLE_CYCLES+1).
  - y=1 and rise=1 after edge E(STABLE_CYCLES+1), which is STABLE_CYCLES+2 edges in total.
- **Fall latency:** identical in the other direction, with `fall` in place of `rise`.
- **Pulse timing:** `rise` and `fall` are high for exactly one cycle, in the same cycle that `y` first shows its new value.
- **Glitch rejection:** a synchronized excursion lasting fewer than STABLE_CYCLES samples never changes `y`. Any opposite sample restarts qualification from zero.
- **Minimum spacing:** consecutive accepted transitions are at least STABLE_CYCLES cycles apart.

## Test plan
All scenarios use STABLE_CYCLES=4.
- **Reset:** hold rst=1 for 3 cycles with a=1, then release. Require y=rise=fall=toggle=0 during reset. Require y=1 with rise=1 for one cycle exactly 6 edges after release.
- **Clean rise and fall:** a goes 0->1 before E0 and is held. Require y=1, rise=1, toggle=1 after E5, and rise=0 after E6. Then a goes 1->0 and is held. Require y=0 and fall=1 for one cycle, 6 edges later; toggle stays 1.
- **Bounce rejection:** with y=0, drive a high for 3 cycles, low for 1 cycle, high for 3 cycles, then low. Require y to stay 0, and rise and fall to never assert.
- **Bounce then settle:** a sequence of 1,0,1,0 (one cycle each), then a held at 1. Require exactly one rise pulse, y=1 six edges after the last 0->1 change, and toggle flipping exactly once.
- **Reset mid-qualification:** a=1, and rst=1 asserted at the edge where cnt=2 in CHK_HIGH. Require state LOW, cnt=0, y=0, and no rise pulse. After release, require the full 6-edge qualification again.
- **Toggle count:** apply 3 clean press/release cycles of a (high 10 cycles, low 10 cycles). Require toggle sequence 1,0,1, three rise pulses and three fall pulses.
